// File: rtl/serial_shift_tx.sv
// rtl/serial_shift_tx.sv - parallel-in, MSB-first serial-out transmitter with frame strobe and done pulse
// Optional even-parity bit after the data bits when SERIAL_SHIFT_TX_PARITY_EN is defined.
module serial_shift_tx #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] tx_data,
  input  logic             tx_valid,
  output logic             tx_ready,
  output logic             ser_out,
  output logic             ser_frame,
  output logic             done
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

`ifdef SERIAL_SHIFT_TX_PARITY_EN
  typedef enum logic [1:0] {IDLE, SHIFT, PAR} state_t;
  logic par_bit;
`else
  typedef enum logic {IDLE, SHIFT} state_t;
`endif

  state_t          state;
  logic [WIDTH-1:0] sreg;   // bits still to be sent, next one at the MSB
  logic [CW-1:0]   count;

  assign tx_ready = reset && (state == IDLE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      sreg      <= '0;
      count     <= '0;
      ser_out   <= 1'b0;
      ser_frame <= 1'b0;
      done      <= 1'b0;
`ifdef SERIAL_SHIFT_TX_PARITY_EN
      par_bit   <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (tx_valid) begin
            sreg      <= {tx_data[WIDTH-2:0], 1'b0};
            ser_out   <= tx_data[WIDTH-1];
            ser_frame <= 1'b1;
            count     <= '0;
            state     <= SHIFT;
`ifdef SERIAL_SHIFT_TX_PARITY_EN
            par_bit   <= ^tx_data;
`endif
          end
        end
        SHIFT: begin
          if (count != LAST) begin
            ser_out <= sreg[WIDTH-1];
            sreg    <= {sreg[WIDTH-2:0], 1'b0};
            count   <= count + CW'(1);
          end else begin
`ifdef SERIAL_SHIFT_TX_PARITY_EN
            ser_out   <= par_bit;
            state     <= PAR;
`else
            ser_out   <= 1'b0;
            ser_frame <= 1'b0;
            done      <= 1'b1;
            state     <= IDLE;
`endif
          end
        end
`ifdef SERIAL_SHIFT_TX_PARITY_EN
        PAR: begin
          ser_out   <= 1'b0;
          ser_frame <= 1'b0;
          done      <= 1'b1;
          state     <= IDLE;
        end
`endif
        default: begin
          ser_out   <= 1'b0;
          ser_frame <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_shift_tx.sv
// tb/tb_serial_shift_tx.sv - scoreboard bench for serial_shift_tx (parity variant via SERIAL_SHIFT_TX_PARITY_EN)
module tb_serial_shift_tx;

  localparam int WIDTH = 8;
`ifdef SERIAL_SHIFT_TX_PARITY_EN
  localparam int FLEN = WIDTH + 1;
`else
  localparam int FLEN = WIDTH;
`endif

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic [WIDTH-1:0] tx_data = '0;
  logic             tx_valid = 1'b0;
  logic             tx_ready;
  logic             ser_out;
  logic             ser_frame;
  logic             done;

  int checks = 0;
  int failures = 0;
  logic exp_q[$];

  serial_shift_tx #(.WIDTH(WIDTH)) dut (
    .clk(clk), .reset(reset), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .ser_out(ser_out), .ser_frame(ser_frame), .done(done)
  );

  always #5 clk = ~clk;

  function automatic void push_word(input logic [WIDTH-1:0] d);
    for (int i = WIDTH - 1; i >= 0; i--) exp_q.push_back(d[i]);
`ifdef SERIAL_SHIFT_TX_PARITY_EN
    exp_q.push_back(^d);
`endif
  endfunction

  task automatic test_reset();
    reset = 1'b0; tx_valid = 1'b1; tx_data = 8'hA5;
    repeat (3) @(negedge clk);
    checks++;
    if ({ser_out, ser_frame, done, tx_ready} !== 4'b0000) begin
      failures++;
      $display("FAIL reset_outputs got=%b exp=0000", {ser_out, ser_frame, done, tx_ready});
    end
    tx_valid = 1'b0;
    reset = 1'b1;
    #1;
    checks++;
    if (tx_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_release_ready got=%b exp=1", tx_ready);
    end
    @(negedge clk);
  endtask

  task automatic test_single();
    logic b;
    tx_valid = 1'b1; tx_data = 8'hA5; push_word(8'hA5);
    @(negedge clk);
    tx_valid = 1'b0;
    for (int i = 0; i < FLEN; i++) begin
      b = exp_q.pop_front();
      checks++;
      if ({ser_out, ser_frame, done, tx_ready} !== {b, 3'b100}) begin
        failures++;
        $display("FAIL single_bit%0d got=%b exp=%b", i, {ser_out, ser_frame, done, tx_ready}, {b, 3'b100});
      end
      @(negedge clk);
    end
    checks++;
    if ({ser_out, ser_frame, done, tx_ready} !== 4'b0011) begin
      failures++;
      $display("FAIL single_done got=%b exp=0011", {ser_out, ser_frame, done, tx_ready});
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0) begin
      failures++;
      $display("FAIL single_done_pulse got=%b exp=0", done);
    end
  endtask

  task automatic test_back_to_back();
    logic b;
    tx_valid = 1'b1; tx_data = 8'hFF; push_word(8'hFF);
    @(negedge clk);
    tx_data = 8'h00;
    for (int i = 0; i < FLEN; i++) begin
      b = exp_q.pop_front();
      checks++;
      if ({ser_out, ser_frame, done} !== {b, 2'b10}) begin
        failures++;
        $display("FAIL b2b_first_bit%0d got=%b exp=%b", i, {ser_out, ser_frame, done}, {b, 2'b10});
      end
      @(negedge clk);
    end
    checks++;
    if ({ser_out, ser_frame, done, tx_ready} !== 4'b0011) begin
      failures++;
      $display("FAIL b2b_gap got=%b exp=0011", {ser_out, ser_frame, done, tx_ready});
    end
    push_word(8'h00);
    @(negedge clk);
    tx_valid = 1'b0;
    for (int i = 0; i < FLEN; i++) begin
      b = exp_q.pop_front();
      checks++;
      if ({ser_out, ser_frame, done} !== {b, 2'b10}) begin
        failures++;
        $display("FAIL b2b_second_bit%0d got=%b exp=%b", i, {ser_out, ser_frame, done}, {b, 2'b10});
      end
      @(negedge clk);
    end
    checks++;
    if ({ser_out, ser_frame, done} !== 3'b001) begin
      failures++;
      $display("FAIL b2b_second_done got=%b exp=001", {ser_out, ser_frame, done});
    end
    @(negedge clk);
  endtask

  task automatic test_busy_ignore();
    logic b;
    tx_valid = 1'b1; tx_data = 8'h3C; push_word(8'h3C);
    @(negedge clk);
    for (int i = 0; i < FLEN; i++) begin
      tx_data = 8'hFF;
      tx_valid = (i % 2 == 0);
      b = exp_q.pop_front();
      checks++;
      if ({ser_out, ser_frame, tx_ready} !== {b, 2'b10}) begin
        failures++;
        $display("FAIL busy_bit%0d got=%b exp=%b", i, {ser_out, ser_frame, tx_ready}, {b, 2'b10});
      end
      @(negedge clk);
    end
    tx_valid = 1'b0;
    checks++;
    if ({ser_frame, done, tx_ready} !== 3'b011) begin
      failures++;
      $display("FAIL busy_done got=%b exp=011", {ser_frame, done, tx_ready});
    end
    @(negedge clk);
    checks++;
    if (ser_frame !== 1'b0) begin
      failures++;
      $display("FAIL busy_no_reaccept got=%b exp=0", ser_frame);
    end
  endtask

  task automatic test_reset_mid_frame();
    logic b;
    tx_valid = 1'b1; tx_data = 8'hA5; push_word(8'hA5);
    @(negedge clk);
    tx_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      b = exp_q.pop_front();
      checks++;
      if ({ser_out, ser_frame} !== {b, 1'b1}) begin
        failures++;
        $display("FAIL midrst_bit%0d got=%b exp=%b", i, {ser_out, ser_frame}, {b, 1'b1});
      end
      @(negedge clk);
    end
    exp_q.delete();
    #2 reset = 1'b0;
    #1;
    checks++;
    if ({ser_out, ser_frame, tx_ready} !== 3'b000) begin
      failures++;
      $display("FAIL midrst_async got=%b exp=000", {ser_out, ser_frame, tx_ready});
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (done !== 1'b0) begin
        failures++;
        $display("FAIL midrst_no_done cyc%0d got=%b exp=0", i, done);
      end
    end
    reset = 1'b1;
    tx_valid = 1'b1; tx_data = 8'h81; push_word(8'h81);
    @(negedge clk);
    tx_valid = 1'b0;
    for (int i = 0; i < FLEN; i++) begin
      b = exp_q.pop_front();
      checks++;
      if ({ser_out, ser_frame} !== {b, 1'b1}) begin
        failures++;
        $display("FAIL midrst_81_bit%0d got=%b exp=%b", i, {ser_out, ser_frame}, {b, 1'b1});
      end
      @(negedge clk);
    end
    checks++;
    if ({ser_frame, done} !== 2'b01) begin
      failures++;
      $display("FAIL midrst_81_done got=%b exp=01", {ser_frame, done});
    end
    @(negedge clk);
  endtask

  task automatic test_parity();
    logic [WIDTH-1:0] words [2];
    logic b;
    words[0] = 8'hA5;
    words[1] = 8'h07;
    for (int w = 0; w < 2; w++) begin
      tx_valid = 1'b1; tx_data = words[w]; push_word(words[w]);
      @(negedge clk);
      tx_valid = 1'b0;
      for (int i = 0; i < FLEN; i++) begin
        b = exp_q.pop_front();
        checks++;
        if ({ser_out, ser_frame, done} !== {b, 2'b10}) begin
          failures++;
          $display("FAIL parity_w%0d_bit%0d got=%b exp=%b", w, i, {ser_out, ser_frame, done}, {b, 2'b10});
        end
        @(negedge clk);
      end
      checks++;
      if ({ser_out, ser_frame, done} !== 3'b001) begin
        failures++;
        $display("FAIL parity_w%0d_done got=%b exp=001", w, {ser_out, ser_frame, done});
      end
      @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_busy_ignore();
    test_reset_mid_frame();
    test_parity();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
